// File: rtl/udma_traffic_pkg.sv
// Shared types and constants for the uDMA traffic generator/checker pair.
// Both ends import this so pattern and config decoding stay identical.
package udma_traffic_pkg;

    typedef enum logic [1:0] {
        MODE_INCR  = 2'b00,
        MODE_LFSR  = 2'b01,
        MODE_CONST = 2'b10,
        MODE_WALK  = 2'b11
    } pattern_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } chk_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    localparam int CFG_EN_BIT   = 0;
    localparam int CFG_MODE_LSB = 1;
    localparam int CFG_MODE_W   = 2;
    localparam int CFG_CLR_BIT  = 3;
    localparam int CFG_THR_LSB  = 4;
    localparam int CFG_THR_W    = 4;
    localparam int CFG_SEED_LSB = 8;
    localparam int CFG_SEED_W   = 8;
    localparam int CFG_LEN_LSB  = 16;
    localparam int CFG_LEN_W    = 16;

    function automatic logic [31:0] pattern_init(
        input pattern_mode_e m,
        input logic [31:0]   s
    );
        logic [31:0] r;
        r = s;
        // all-zero would lock the LFSR and walking-one patterns
        if ((m == MODE_LFSR || m == MODE_WALK) && s == 32'h0)
            r = 32'h1;
        return r;
    endfunction

    function automatic logic [31:0] pattern_next(
        input pattern_mode_e m,
        input logic [31:0]   e
    );
        logic [31:0] r;
        r = e;
        unique case (m)
            MODE_INCR:  r = e + 32'h1;
            MODE_LFSR:  r = {1'b0, e[31:1]} ^ ({32{e[0]}} & LFSR_POLY);
            MODE_CONST: r = e;
            MODE_WALK:  r = {e[30:0], e[31]};
            default:    r = e;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/udma_traffic_pattern.sv
// Expected-word register: loads the initial pattern and steps it per word.
// Mode is captured on load so live config changes cannot disturb a run.
module udma_traffic_pattern
    import udma_traffic_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_load,
    input  logic          i_step,
    input  pattern_mode_e i_mode,
    input  logic [31:0]   i_seed,
    output logic [31:0]   o_data
);

    pattern_mode_e r_mode;
    logic [31:0]   r_data;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_mode <= MODE_INCR;
            r_data <= 32'h0;
        end else if (i_load) begin
            r_mode <= i_mode;
            r_data <= pattern_init(i_mode, i_seed);
        end else if (i_step) begin
            r_data <= pattern_next(r_mode, r_data);
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/udma_traffic_checker.sv
// Sink end of the uDMA traffic pair: checks the TX stream against a local
// pattern, counts mismatches and throttles ready to exercise backpressure.
module udma_traffic_checker
    import udma_traffic_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic [31:0]           cfg_setup_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  rx_cnt_o,
    output logic [CNT_WIDTH-1:0]  err_cnt_o,
    output logic [CNT_WIDTH-1:0]  first_err_idx_o
);

    logic                 w_en;
    logic                 w_clr;
    logic [3:0]           w_thr;
    pattern_mode_e        w_mode;
    logic [31:0]          w_seed;
    logic [CNT_WIDTH-1:0] w_len;

    assign w_en   = cfg_setup_i[CFG_EN_BIT];
    assign w_clr  = cfg_setup_i[CFG_CLR_BIT];
    assign w_thr  = cfg_setup_i[CFG_THR_LSB +: CFG_THR_W];
    assign w_mode = pattern_mode_e'(cfg_setup_i[CFG_MODE_LSB +: CFG_MODE_W]);
    assign w_seed = {4{cfg_setup_i[CFG_SEED_LSB +: CFG_SEED_W]}};
    assign w_len  = CNT_WIDTH'(cfg_setup_i[CFG_LEN_LSB +: CFG_LEN_W]);

    chk_state_e           r_state;
    chk_state_e           w_state_nxt;
    logic                 r_ready;
    logic                 r_err;
    logic [3:0]           r_thr;
    logic [CNT_WIDTH-1:0] r_len;
    logic [CNT_WIDTH-1:0] r_rx;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic [CNT_WIDTH-1:0] r_first;

    logic                 w_accept;
    logic                 w_start;
    logic                 w_last;
    logic                 w_mismatch;
    logic [3:0]           w_thr_nxt;
    logic [CNT_WIDTH-1:0] w_rx_inc;
    logic [31:0]          w_exp;

    assign w_accept   = valid_i && r_ready;
    assign w_start    = (r_state == ST_IDLE) && (w_state_nxt == ST_RUN);
    assign w_rx_inc   = r_rx + CNT_WIDTH'(1);
    assign w_last     = (r_len != '0) && (w_rx_inc == r_len);
    assign w_mismatch = (data_i != w_exp);
    assign w_thr_nxt  = (r_thr >= w_thr) ? 4'd0 : r_thr + 4'd1;

    always_ff @(posedge clk_i) begin
        if (!rstn_i)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: if (w_en) w_state_nxt = ST_RUN;
                ST_RUN: begin
                    // abort wins over a coincident final accept
                    if (!w_en)
                        w_state_nxt = ST_IDLE;
                    else if (w_accept && w_last)
                        w_state_nxt = ST_DONE;
                end
                ST_DONE: if (!w_en) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (r_state == ST_RUN);
        done_o = (r_state == ST_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_thr     <= 4'd0;
            r_len     <= '0;
            r_rx      <= '0;
            r_err_cnt <= '0;
            r_first   <= '0;
        end else if (w_clr) begin
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_thr     <= 4'd0;
            r_rx      <= '0;
            r_err_cnt <= '0;
            r_first   <= '0;
        end else begin
            if (w_start) begin
                r_err     <= 1'b0;
                r_thr     <= 4'd0;
                r_len     <= w_len;
                r_rx      <= '0;
                r_err_cnt <= '0;
                r_first   <= '0;
            end else if (r_state == ST_RUN) begin
                r_thr <= w_thr_nxt;
            end
            // ready mirrors "throttle counter == 0" for the coming cycle
            r_ready <= (w_state_nxt == ST_RUN) &&
                       (w_start || (w_thr_nxt == 4'd0));
            if (w_accept) begin
                r_rx <= w_rx_inc;
                if (w_mismatch) begin
                    r_err <= 1'b1;
                    if (!r_err)
                        r_first <= r_rx;
                    if (r_err_cnt != '1)
                        r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    udma_traffic_pattern u_pattern (
        .i_clk  (clk_i),
        .i_rstn (rstn_i),
        .i_load (w_start),
        .i_step (w_accept && !w_clr),
        .i_mode (w_mode),
        .i_seed (w_seed),
        .o_data (w_exp)
    );

    assign ready_o         = r_ready;
    assign err_o           = r_err;
    assign rx_cnt_o        = r_rx;
    assign err_cnt_o       = r_err_cnt;
    assign first_err_idx_o = r_first;

endmodule

// File: tb/tb_udma_traffic_checker.sv
// Directed bench for udma_traffic_checker: handshake, patterns, throttle,
// clear/reset, abort and counter saturation.
module tb_udma_traffic_checker;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] cfg;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] rx_cnt;
    logic [15:0] err_cnt;
    logic [15:0] first_idx;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    udma_traffic_checker dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .cfg_setup_i     (cfg),
        .data_i          (data),
        .valid_i         (valid),
        .ready_o         (ready),
        .busy_o          (busy),
        .done_o          (done),
        .err_o           (err),
        .rx_cnt_o        (rx_cnt),
        .err_cnt_o       (err_cnt),
        .first_err_idx_o (first_idx)
    );

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk_cfg(
        input logic en, input logic [1:0] mode, input logic clr,
        input logic [3:0] thr, input logic [7:0] seed,
        input logic [15:0] len);
        return {len, seed, thr, clr, mode, en};
    endfunction

    // waits (bounded) for ready, then presents one word for one cycle
    task automatic send(input logic [31:0] w, output int waited);
        waited = 0;
        while (!ready && waited < 32) begin
            tick();
            waited++;
        end
        if (!ready) begin
            check("send_timeout", 32'(ready), 32'd1);
        end else begin
            data  = w;
            valid = 1'b1;
            tick();
            valid = 1'b0;
        end
    endtask

    initial begin
        int w;
        int nrdy;
        rstn  = 1'b0;
        cfg   = 32'h0;
        data  = 32'h0;
        valid = 1'b0;
        tick();
        tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rx", 32'(rx_cnt), 32'd0);
        rstn = 1'b1;

        // 1: incr, back-to-back, L=4
        cfg = mk_cfg(1'b1, 2'b00, 1'b0, 4'd0, 8'h10, 16'd4);
        tick();
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            send(32'h1010_1010 + 32'(i), w);
            check("t1_nowait", 32'(w), 32'd0);
        end
        check("t1_done", 32'(done), 32'd1);
        check("t1_rx", 32'(rx_cnt), 32'd4);
        check("t1_errcnt", 32'(err_cnt), 32'd0);
        check("t1_ready", 32'(ready), 32'd0);
        tick();
        check("t1_done_hold", 32'(done), 32'd1);
        cfg = 32'h0;
        tick();
        check("t1_idle", 32'(done), 32'd0);

        // 2: LFSR, seed 0 replaced by 1
        cfg = mk_cfg(1'b1, 2'b01, 1'b0, 4'd0, 8'h00, 16'd3);
        tick();
        send(32'h0000_0001, w);
        send(32'h8020_0003, w);
        send(32'hC030_0002, w);
        check("t2_done", 32'(done), 32'd1);
        check("t2_err", 32'(err), 32'd0);
        check("t2_rx", 32'(rx_cnt), 32'd3);
        cfg = 32'h0;
        tick();

        // 3: incr with words 2 and 5 corrupted
        cfg = mk_cfg(1'b1, 2'b00, 1'b0, 4'd0, 8'h20, 16'd8);
        tick();
        for (int i = 0; i < 8; i++) begin
            send((32'h2020_2020 + 32'(i)) ^ ((i == 2 || i == 5) ? 32'h100 : 32'h0), w);
        end
        check("t3_errcnt", 32'(err_cnt), 32'd2);
        check("t3_first", 32'(first_idx), 32'd2);
        check("t3_err", 32'(err), 32'd1);
        check("t3_rx", 32'(rx_cnt), 32'd8);
        check("t3_done", 32'(done), 32'd1);
        cfg = 32'h0;
        tick();

        // 4: throttle T=3, unbounded, valid held high
        cfg = mk_cfg(1'b1, 2'b10, 1'b0, 4'd3, 8'h5A, 16'd0);
        tick();
        data  = 32'h5A5A_5A5A;
        valid = 1'b1;
        nrdy  = 0;
        for (int i = 0; i < 16; i++) begin
            check("t4_busy", 32'(busy), 32'd1);
            check("t4_ready", 32'(ready), (i % 4 == 0) ? 32'd1 : 32'd0);
            if (ready) nrdy++;
            tick();
        end
        valid = 1'b0;
        check("t4_nrdy", 32'(nrdy), 32'd4);
        check("t4_rx", 32'(rx_cnt), 32'd4);
        check("t4_err", 32'(err), 32'd0);
        cfg = 32'h0;
        tick();

        // 5: clear with a coincident accept, then reset mid-run
        cfg = mk_cfg(1'b1, 2'b00, 1'b0, 4'd0, 8'h30, 16'd0);
        tick();
        for (int i = 0; i < 5; i++) send(32'h3030_3030 + 32'(i), w);
        check("t5_rx5", 32'(rx_cnt), 32'd5);
        cfg   = mk_cfg(1'b1, 2'b00, 1'b1, 4'd0, 8'h30, 16'd0);
        data  = 32'h3030_3035;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("t5_clr_busy", 32'(busy), 32'd0);
        check("t5_clr_rx", 32'(rx_cnt), 32'd0);
        check("t5_clr_ready", 32'(ready), 32'd0);
        tick();
        check("t5_clr_hold", 32'(busy), 32'd0);
        cfg = mk_cfg(1'b1, 2'b00, 1'b0, 4'd0, 8'h30, 16'd0);
        tick();
        check("t5_restart", 32'(busy), 32'd1);
        send(32'h3030_3030, w);
        send(32'h3030_3031, w);
        send(32'hDEAD_BEEF, w);
        check("t5_rx3", 32'(rx_cnt), 32'd3);
        check("t5_first", 32'(first_idx), 32'd2);
        check("t5_errcnt", 32'(err_cnt), 32'd1);
        rstn = 1'b0;
        tick();
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_ready", 32'(ready), 32'd0);
        check("t5_rst_err", 32'(err), 32'd0);
        check("t5_rst_rx", 32'(rx_cnt), 32'd0);
        check("t5_rst_errcnt", 32'(err_cnt), 32'd0);
        check("t5_rst_first", 32'(first_idx), 32'd0);
        rstn = 1'b1;
        cfg  = 32'h0;
        tick();

        // abort coinciding with the final accept
        cfg = mk_cfg(1'b1, 2'b00, 1'b0, 4'd0, 8'h40, 16'd2);
        tick();
        send(32'h4040_4040, w);
        cfg   = mk_cfg(1'b0, 2'b00, 1'b0, 4'd0, 8'h40, 16'd2);
        data  = 32'h4040_4041;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_done", 32'(done), 32'd0);
        check("ab_rx", 32'(rx_cnt), 32'd2);
        check("ab_err", 32'(err), 32'd0);
        tick();

        // 6: saturation and wrap
        cfg = mk_cfg(1'b1, 2'b10, 1'b0, 4'd0, 8'h00, 16'd0);
        tick();
        check("t6_ready", 32'(ready), 32'd1);
        data  = 32'hFFFF_FFFF;
        valid = 1'b1;
        for (int i = 0; i < 65537; i++) tick();
        valid = 1'b0;
        check("t6_errcnt", 32'(err_cnt), 32'h0000_FFFF);
        check("t6_rx", 32'(rx_cnt), 32'd1);
        check("t6_first", 32'(first_idx), 32'd0);
        check("t6_err", 32'(err), 32'd1);
        check("t6_busy", 32'(busy), 32'd1);
        cfg = 32'h0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
